// File: rtl/wb_pio_pkg.sv
// Shared definitions for the Wishbone-to-PIO bridge: action codes, register map, FSM states.
package wb_pio_pkg;

    localparam logic [3:0] ACT_NONE = 4'h0;
    localparam logic [3:0] ACT_PUSH = 4'h1;
    localparam logic [3:0] ACT_PULL = 4'h2;

    localparam logic [1:0] REG_ACTION = 2'b00;
    localparam logic [1:0] REG_CTRL   = 2'b01;

    localparam logic [7:0] OFS_INDEX   = 8'h40;
    localparam logic [7:0] OFS_STATUS  = 8'h44;
    localparam logic [7:0] OFS_PENDING = 8'h48;
    localparam logic [7:0] OFS_MASK    = 8'h4C;

    localparam logic [31:0] POISON = 32'hDEAD_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_CAPTURE,
        ST_ACK
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wb_pio_irq_ctrl.sv
// Per-PIO interrupt block: rising-edge capture of irq0/irq1 into pending, W1C, mask, registered irq.
module wb_pio_irq_ctrl (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       irq0,
    input  logic       irq1,
    input  logic       mask_we,
    input  logic [1:0] mask_wdata,
    input  logic       w1c_we,
    input  logic [1:0] w1c_data,
    output logic [1:0] pending,
    output logic [1:0] mask,
    output logic       irq
);
    logic [1:0] irq_prev;
    logic [1:0] rise;
    logic [1:0] clr;

    assign rise = {irq1, irq0} & ~irq_prev;
    assign clr  = w1c_we ? w1c_data : 2'b00;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            irq_prev <= {irq1, irq0};
            // a new edge in the same cycle as a clear keeps the bit set
            pending  <= (pending & ~clr) | rise;
            if (mask_we)
                mask <= mask_wdata;
            irq      <= |(pending & mask);
        end
    end

endmodule

// File: rtl/wb_pio_bridge.sv
// Wishbone slave front-end for NUM_PIO PIO cores: action window, index/mindex, status, IRQ.
// Optional stall timeout in CHECK is enabled by defining WB_PIO_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a selected access
// CHECK   | waiting for FIFO readiness of the target state machine
// ISSUE   | drive pio_action for one cycle
// CAPTURE | latch pio_dout of the target instance (reads only)
// ACK     | acknowledge the access
module wb_pio_bridge
    import wb_pio_pkg::*;
#(
    parameter int          NUM_PIO   = 2,
    parameter logic [15:0] BASE_ADDR = 16'h761c,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PIO-1:0]      irq_o,
    output logic [31:0]             pio_din,
    output logic [4:0]              pio_index,
    output logic [2*NUM_PIO-1:0]    pio_mindex,
    output logic [4*NUM_PIO-1:0]    pio_action,
    input  logic [32*NUM_PIO-1:0]   pio_dout,
    input  logic [NUM_PIO-1:0]      pio_irq0,
    input  logic [NUM_PIO-1:0]      pio_irq1,
    input  logic [4*NUM_PIO-1:0]    pio_tx_full,
    input  logic [4*NUM_PIO-1:0]    pio_rx_empty
);
    localparam int PW = (NUM_PIO > 1) ? $clog2(NUM_PIO) : 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q;
    logic [3:0]      a_q;
    logic            we_q, drop_q, ack_ctrl_q, ack_fsm;
    logic            tmo_sticky, tmo_hit, ready;
    logic [31:0]     ctrl_rdata;

    logic [31:0]     dout_arr   [NUM_PIO];
    logic [3:0]      txf_arr    [NUM_PIO];
    logic [3:0]      rxe_arr    [NUM_PIO];
    logic [1:0]      mindex_q   [NUM_PIO];
    logic [1:0]      pending    [NUM_PIO];
    logic [1:0]      mask       [NUM_PIO];
    logic [NUM_PIO-1:0] mask_we, w1c_we;

    logic            sel, p_valid, accept, act_start, ctrl_start, ctrl_hit, ctrl_wr, status_rd;
    logic [3:0]      adr_p;
    logic [1:0]      region;
    logic [3:0]      code;
    logic [7:0]      ofs;
    logic [PW-1:0]   p_idx;
    logic            unused_adr;

    assign sel        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADDR);
    assign adr_p      = wbs_adr_i[11:8];
    assign region     = wbs_adr_i[7:6];
    assign code       = wbs_adr_i[5:2];
    assign ofs        = {wbs_adr_i[7:2], 2'b00};
    assign p_idx      = adr_p[PW-1:0];
    assign p_valid    = ({28'b0, adr_p} < 32'(NUM_PIO));
    assign unused_adr = ^{wbs_adr_i[15:12], wbs_adr_i[1:0]};

    assign accept     = sel & ~wbs_ack_o & (state_q == ST_IDLE);
    assign act_start  = accept & p_valid & (region == REG_ACTION);
    assign ctrl_start = accept & ~act_start;
    assign ctrl_hit   = ctrl_start & p_valid & (region == REG_CTRL);
    assign ctrl_wr    = ctrl_hit & wbs_we_i;
    assign status_rd  = ctrl_hit & ~wbs_we_i & (ofs == OFS_STATUS);

    for (genvar i = 0; i < NUM_PIO; i++) begin : g_pio
        assign dout_arr[i]       = pio_dout[32*i +: 32];
        assign txf_arr[i]        = pio_tx_full[4*i +: 4];
        assign rxe_arr[i]        = pio_rx_empty[4*i +: 4];
        assign pio_mindex[2*i +: 2] = mindex_q[i];
        assign mask_we[i] = ctrl_wr & (ofs == OFS_MASK)    & (p_idx == PW'(i)) & wbs_sel_i[0];
        assign w1c_we[i]  = ctrl_wr & (ofs == OFS_PENDING) & (p_idx == PW'(i)) & wbs_sel_i[0];

        wb_pio_irq_ctrl u_irq (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_i   (wb_rst_i),
            .irq0       (pio_irq0[i]),
            .irq1       (pio_irq1[i]),
            .mask_we    (mask_we[i]),
            .mask_wdata (wbs_dat_i[1:0]),
            .w1c_we     (w1c_we[i]),
            .w1c_data   (wbs_dat_i[1:0]),
            .pending    (pending[i]),
            .mask       (mask[i]),
            .irq        (irq_o[i])
        );
    end

    always_comb begin
        case (a_q)
            ACT_PUSH: ready = ~txf_arr[p_q][mindex_q[p_q]];
            ACT_PULL: ready = ~rxe_arr[p_q][mindex_q[p_q]];
            default:  ready = 1'b1;
        endcase
    end

`ifdef WB_PIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            tmo_cnt <= '0;
        else if (act_start)
            tmo_cnt <= CW'(TIMEOUT - 1);
        else if (state_q == ST_CHECK && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
    end

    assign tmo_hit = (state_q == ST_CHECK) & wbs_cyc_i & ~ready & (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (act_start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!wbs_cyc_i)   state_d = ST_IDLE;
                else if (ready)   state_d = ST_ISSUE;
                else if (tmo_hit) state_d = ST_ACK;
            end
            ST_ISSUE:   state_d = we_q ? ST_ACK : ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ACK;
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pio_action = '0;
        for (int i = 0; i < NUM_PIO; i++)
            if (state_q == ST_ISSUE && p_q == PW'(i))
                pio_action[4*i +: 4] = a_q;
        ack_fsm = (state_q == ST_ACK) & ~drop_q & wbs_cyc_i;
    end

    assign wbs_ack_o = ack_fsm | ack_ctrl_q;

    always_comb begin
        ctrl_rdata = '0;
        if (p_valid && region == REG_CTRL) begin
            case (ofs)
                OFS_INDEX:   ctrl_rdata = {22'b0, mindex_q[p_idx], 3'b0, pio_index};
                OFS_STATUS:  ctrl_rdata = {23'b0, tmo_sticky, rxe_arr[p_idx], txf_arr[p_idx]};
                OFS_PENDING: ctrl_rdata = {30'b0, pending[p_idx]};
                OFS_MASK:    ctrl_rdata = {30'b0, mask[p_idx]};
                default:     ctrl_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            p_q        <= '0;
            a_q        <= ACT_NONE;
            we_q       <= 1'b0;
            drop_q     <= 1'b0;
            ack_ctrl_q <= 1'b0;
            wbs_dat_o  <= '0;
            pio_din    <= '0;
            pio_index  <= '0;
            tmo_sticky <= 1'b0;
            for (int i = 0; i < NUM_PIO; i++)
                mindex_q[i] <= '0;
        end else begin
            ack_ctrl_q <= ctrl_start;
            if (act_start) begin
                p_q    <= p_idx;
                a_q    <= code;
                we_q   <= wbs_we_i;
                drop_q <= 1'b0;
                if (wbs_we_i)
                    pio_din <= byte_merge(pio_din, wbs_dat_i, wbs_sel_i);
            end
            // once the action is out, a dropped cycle only suppresses the ack
            if ((state_q == ST_ISSUE || state_q == ST_CAPTURE || state_q == ST_ACK) && !wbs_cyc_i)
                drop_q <= 1'b1;
            if (state_q == ST_CAPTURE)
                wbs_dat_o <= dout_arr[p_q];
            if (tmo_hit)
                wbs_dat_o <= POISON | {28'b0, a_q};
            if (ctrl_start)
                wbs_dat_o <= ctrl_rdata;
            if (ctrl_wr && ofs == OFS_INDEX) begin
                if (wbs_sel_i[0]) pio_index <= wbs_dat_i[4:0];
                if (wbs_sel_i[1]) mindex_q[p_idx] <= wbs_dat_i[9:8];
            end
            if (tmo_hit)
                tmo_sticky <= 1'b1;
            else if (status_rd)
                tmo_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_pio_bridge.sv
// Directed self-checking bench for wb_pio_bridge (NUM_PIO=2); timeout case runs when WB_PIO_TIMEOUT_EN is defined.
module tb_wb_pio_bridge;
    localparam int NP = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]      wbs_sel_i = '0;
    logic [31:0]     wbs_dat_i = '0, wbs_adr_i = '0;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [NP-1:0]   irq_o;
    logic [31:0]     pio_din;
    logic [4:0]      pio_index;
    logic [2*NP-1:0] pio_mindex;
    logic [4*NP-1:0] pio_action;
    logic [32*NP-1:0] pio_dout = '0;
    logic [NP-1:0]   pio_irq0 = '0, pio_irq1 = '0;
    logic [4*NP-1:0] pio_tx_full = '0, pio_rx_empty = '0;

    int n_chk = 0, n_pass = 0;
    int rel_at = 0, act_cycles, ack_cycles, lat;
    logic [31:0] act_seen, rdat;

    wb_pio_bridge #(.NUM_PIO(NP), .BASE_ADDR(16'h761c), .TIMEOUT(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o),
        .pio_din(pio_din), .pio_index(pio_index), .pio_mindex(pio_mindex),
        .pio_action(pio_action), .pio_dout(pio_dout),
        .pio_irq0(pio_irq0), .pio_irq1(pio_irq1),
        .pio_tx_full(pio_tx_full), .pio_rx_empty(pio_rx_empty)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int lt);
        act_cycles = 0;
        act_seen   = '0;
        lt         = -1;
        rd         = '0;
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == rel_at) begin pio_tx_full = '0; pio_rx_empty = '0; end
            if (pio_action != '0) begin act_cycles++; act_seen = 32'(pio_action); end
            if (wbs_ack_o) begin lt = n; rd = wbs_dat_o; break; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        rel_at = 0;
        if (lt < 0) chk("ack_bound", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        #22;
        chk("rst_ack",    32'(wbs_ack_o),  32'd0);
        chk("rst_dat",    wbs_dat_o,       32'd0);
        chk("rst_action", 32'(pio_action), 32'd0);
        chk("rst_irq",    32'(irq_o),      32'd0);
        @(negedge wb_clk_i) wb_rst_i = 1'b0;
        step();

        // push write to p=1
        wb_xfer(32'h761c_0104, 1'b1, 32'hA5A5_1234, 4'hF, rdat, lat);
        chk("push_lat",   32'(lat),    32'd3);
        chk("push_din",   pio_din,     32'hA5A5_1234);
        chk("push_pulse", 32'(act_cycles), 32'd1);
        chk("push_act",   act_seen,    32'h0000_0010);

        // stalled pull read from p=0
        pio_dout = {32'h1111_2222, 32'h0000_BEEF};
        pio_rx_empty[0] = 1'b1;
        rel_at = 6;
        wb_xfer(32'h761c_0008, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("pull_lat",   32'(lat),    32'd9);
        chk("pull_data",  rdat,        32'h0000_BEEF);
        chk("pull_pulse", 32'(act_cycles), 32'd1);
        chk("pull_act",   act_seen,    32'h0000_0002);

        // index / mindex with byte lanes
        wb_xfer(32'h761c_0040, 1'b1, 32'h0000_0213, 4'hF, rdat, lat);
        chk("idx_lat",    32'(lat),       32'd1);
        chk("idx_index",  32'(pio_index), 32'h13);
        chk("idx_mindex", 32'(pio_mindex), 32'h2);
        wb_xfer(32'h761c_0040, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("idx_rd",     rdat,           32'h0000_0213);
        wb_xfer(32'h761c_0040, 1'b1, 32'h0000_0115, 4'b0001, rdat, lat);
        chk("idx_lane",   32'(pio_mindex), 32'h2);
        wb_xfer(32'h761c_0040, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("idx_rd2",    rdat,           32'h0000_0215);

        // irq: mask, edge, W1C, coincident set
        wb_xfer(32'h761c_014C, 1'b1, 32'h3, 4'hF, rdat, lat);
        pio_irq1[1] = 1'b1; step(); pio_irq1[1] = 1'b0; step(); step();
        chk("irq_set",    32'(irq_o), 32'h2);
        wb_xfer(32'h761c_0148, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("pend_p1",    rdat, 32'h2);
        wb_xfer(32'h761c_0048, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("pend_p0",    rdat, 32'h0);
        wb_xfer(32'h761c_0148, 1'b1, 32'h2, 4'hF, rdat, lat);
        chk("irq_w1c",    32'(irq_o), 32'h0);
        pio_irq1[1] = 1'b1;
        wb_xfer(32'h761c_0148, 1'b1, 32'h2, 4'hF, rdat, lat);
        chk("irq_coinc",  32'(irq_o), 32'h2);
        wb_xfer(32'h761c_0148, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("pend_coinc", rdat, 32'h2);
        wb_xfer(32'h761c_0148, 1'b1, 32'h2, 4'hF, rdat, lat);
        wb_xfer(32'h761c_0148, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("pend_level", rdat, 32'h0);
        pio_irq1[1] = 1'b0; step();
        pio_irq1[1] = 1'b1; step(); step(); step();
        chk("irq_again",  32'(irq_o), 32'h2);

        // out-of-range instance and reserved region
        wb_xfer(32'h761c_0740, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("p7_lat",  32'(lat), 32'd1);
        chk("p7_data", rdat,     32'h0);
        wb_xfer(32'h761c_0180, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("rsv_data", rdat,    32'h0);
        wb_xfer(32'h761c_0304, 1'b1, 32'h0, 4'hF, rdat, lat);
        chk("p3_lat",  32'(lat), 32'd1);
        chk("p3_act",  32'(act_cycles), 32'd0);

        // cyc dropped while stalled in CHECK
        pio_tx_full[4] = 1'b1;
        pio_rx_empty[7:4] = 4'hA;
        act_cycles = 0; ack_cycles = 0;
        wbs_adr_i = 32'h761c_0104; wbs_we_i = 1'b1; wbs_dat_i = 32'h55; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; end
            step();
            if (pio_action != '0) act_cycles++;
            if (wbs_ack_o) ack_cycles++;
        end
        chk("drop_act", 32'(act_cycles), 32'd0);
        chk("drop_ack", 32'(ack_cycles), 32'd0);
        wb_xfer(32'h761c_0144, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("status_p1", rdat, 32'h0000_00A1);

`ifdef WB_PIO_TIMEOUT_EN
        wb_xfer(32'h761c_0104, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("tmo_lat",  32'(lat), 32'd17);
        chk("tmo_act",  32'(act_cycles), 32'd0);
        chk("tmo_data", rdat, 32'hDEAD_0001);
        wb_xfer(32'h761c_0144, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("tmo_sticky", rdat, 32'h0000_01A1);
        wb_xfer(32'h761c_0144, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("tmo_clear",  rdat, 32'h0000_00A1);
`endif

        // async reset while stalled in CHECK
        wbs_adr_i = 32'h761c_0104; wbs_we_i = 1'b1; wbs_dat_i = 32'h77; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step(); step();
        #2 wb_rst_i = 1'b1;
        #1;
        chk("arst_ack",    32'(wbs_ack_o),  32'd0);
        chk("arst_din",    pio_din,         32'd0);
        chk("arst_index",  32'(pio_index),  32'd0);
        chk("arst_mindex", 32'(pio_mindex), 32'd0);
        chk("arst_irq",    32'(irq_o),      32'd0);
        chk("arst_action", 32'(pio_action), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        pio_tx_full = '0; pio_rx_empty = '0; pio_irq1 = '0;
        @(negedge wb_clk_i) wb_rst_i = 1'b0;
        step();
        wb_xfer(32'h761c_0740, 1'b0, 32'h0, 4'hF, rdat, lat);
        chk("post_p7_lat",  32'(lat), 32'd1);
        chk("post_p7_data", rdat,     32'h0);
        wb_xfer(32'h761c_000C, 1'b1, 32'h1, 4'hF, rdat, lat);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_act", act_seen, 32'h0000_0003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
